renesas_i2c_target: RTL and testbench
=====================================

# renesas_i2c_target

Synthesizable I2C target (responder) that models the Renesas jitter-attenuator register port seen by the `clk_recov` I2C master on CLKGEN_SDA/CLKGEN_SCL. It oversamples SCL/SDA on the system clock, decodes START/STOP, address, register pointer and data bytes, and serves writes and auto-incrementing reads from an internal register file. It also exposes a write-event strobe and a host read port, so a bench or monitor logic can check what the master programmed.

## Interface
- `DEV_ADDR`, 7'h5B, 7-bit target address to match.
- `REG_AW`, 8, register file address width; depth = 2**REG_AW bytes.
- `FILTER_LEN`, 3, number of consecutive equal synchronized samples needed to accept a new SCL/SDA level.
- `HOLD_CYC`, 4, aclk cycles after an accepted SCL fall before `sda_oe` may change.

Ports:
- `aclk`  in  1  system clock (at least 20x SCL rate).
- `aresetn`  in  1  asynchronous active-low reset.
- `scl_i`  in  1  SCL pad input.
- `sda_i`  in  1  SDA pad input.
- `sda_oe`  out  1  1 = pull SDA low (open drain); 0 = release.
- `busy`  out  1  high from an addressed START until STOP or NACK.
- `wr_stb`  out  1  one-cycle pulse per accepted write data byte.
- `wr_addr`  out  REG_AW  register address of the last write.
- `wr_data`  out  8  data of the last write.
- `host_raddr`  in  REG_AW  host read address.
- `host_rdata`  out  8  register contents at `host_raddr`, registered.

## Operation
- Input path: 2-FF synchronizer, then a FILTER_LEN glitch filter, giving `scl_f`/`sda_f` and one-cycle edge flags.
- Bus conditions:
  - START/repeated START: `sda_f` falls while `scl_f` = 1.
  - STOP: `sda_f` rises while `scl_f` = 1.
  - Both abort any state. START goes to ADDR. STOP goes to IDLE and releases `sda_oe`.
- Bit sampling happens on the `scl_f` rise. A 3-bit counter counts bits MSB first; the 9th bit is ACK/NACK.
- States:
  - IDLE
  - ADDR: shift 8 bits.
    - `addr[7:1]` == DEV_ADDR, R/W = 0 → ACK, then PTR.
    - Match with R/W = 1 → ACK, then RDATA.
    - No match → no ACK, go to IGNORE.
  - PTR: byte loads the pointer (low REG_AW bits; upper bits dropped); ACK → WDATA.
  - WDATA: each byte is written to `reg[ptr]`, `wr_stb` pulses, ACK, then `ptr` increments.
  - RDATA:
    - Drive `reg[ptr]` MSB first. `sda_oe = ~bit`.
    - Release SDA during the 9th bit. `ptr` increments after the byte.
    - Master ACK (SDA low) → next byte. NACK → IGNORE.
  - IGNORE: `sda_oe` = 0 until START or STOP.
- The pointer wraps modulo 2**REG_AW in both directions of access.
- The pointer persists across transactions (repeated START with R/W = 1 reads from the last pointer). It is reset to 0.
- Register file: 2**REG_AW × 8, all 0 at reset. The host read port has 1-cycle latency and reflects same-cycle writes on the next cycle.
- Reset mid-transaction returns to IDLE immediately. Subsequent bus activity is ignored until the next START.

## Timing
- Reset values: `sda_oe` = 0, `busy` = 0, `wr_stb` = 0, `wr_addr` = 0, `wr_data` = 0, `host_rdata` = 0, `ptr` = 0, state IDLE.
- Input latency: pad edge to edge flag = 2 + FILTER_LEN cycles.
- `sda_oe` changes only HOLD_CYC cycles after an accepted `scl_f` fall, never while `scl_f` = 1. The exception is STOP/START, which release it within 1 cycle.
- ACK assertion: on the fall ending bit 8, plus HOLD_CYC. Released on the fall ending bit 9, plus HOLD_CYC.
- Read data bit 1 is driven on the fall that ends the address ACK, plus HOLD_CYC.
- `wr_stb` fires 1 cycle after the 8th-bit rise of a data byte. `wr_addr`/`wr_data` update in the same cycle and hold until the next write.
- `busy` rises the cycle the address ACK is decided and falls the cycle of STOP or IGNORE entry.
- START detected during a data bit discards the partial byte; no write, no `wr_stb`.

## Test plan
- Write: START, 0xB6, 0x10, 0xAA, 0x55, STOP → 3 ACKs plus 1 more. `wr_stb` twice: (0x10, 0xAA), (0x11, 0x55). `host_raddr` = 0x11 → `host_rdata` = 0x55.
- Random read: START 0xB6 0x10, repeated START 0xB7, read 2 bytes with ACK then NACK, STOP → SDA carries 0xAA, 0x55. `sda_oe` = 0 after NACK.
- Address mismatch: START 0xA0, 0x00, STOP → no ACK on any bit. `busy` stays 0, `wr_stb` never pulses.
- Wrap: write pointer 0xFF, data 0x01, 0x02 → `reg[0xFF]` = 0x01, `reg[0x00]` = 0x02.
- Glitch/abort:
  - A 2-cycle SDA pulse during SCL high produces no START/STOP.
  - A START injected after 4 data bits produces no `wr_stb`.
  - `aresetn` low mid-read forces `sda_oe` = 0 within the asynchronous reset, and all outputs return to their reset values.
- Hold check: for every `sda_oe` transition outside START/STOP, `scl_f` = 0 and at least HOLD_CYC cycles have passed since the last SCL fall.

Source files
------------

// File: rtl/renesas_i2c_target.sv
// I2C target modelling the Renesas jitter-attenuator register port.
// SCL/SDA are oversampled on aclk, synchronized and glitch filtered. The
// filtered lines drive a byte-level FSM that serves pointer writes, data
// writes and auto-incrementing reads from a resettable register file.
module renesas_i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h5B,
    parameter int         REG_AW     = 8,
    parameter int         FILTER_LEN = 3,
    parameter int         HOLD_CYC   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_stb,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] host_raddr,
    output logic [7:0]        host_rdata
);

    localparam int DEPTH = 1 << REG_AW;
    localparam int FCW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int HCW   = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PTR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through the input path.
    logic [1:0] pad_in;
    logic [1:0] line_f;
    logic [1:0] line_rise;
    logic [1:0] line_fall;

    assign pad_in = {sda_i, scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            logic           sync1_reg;
            logic           sync2_reg;
            logic           filt_reg;
            logic           rise_reg;
            logic           fall_reg;
            logic [FCW-1:0] cnt_reg;

            // Two-flop synchronizer, then accept a new level only after
            // FILTER_LEN consecutive differing samples; edge flags pulse with
            // the accepted change.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pad_in[gi];
                    sync2_reg <= sync1_reg;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FCW'(FILTER_LEN - 1)) begin
                        filt_reg <= sync2_reg;
                        rise_reg <= sync2_reg;
                        fall_reg <= ~sync2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign line_f[gi]    = filt_reg;
            assign line_rise[gi] = rise_reg;
            assign line_fall[gi] = fall_reg;
        end
    endgenerate

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c, active;
    assign scl_f    = line_f[0];
    assign sda_f    = line_f[1];
    assign scl_rise = line_rise[0];
    assign scl_fall = line_fall[0];
    assign start_c  = line_fall[1] && scl_f;
    assign stop_c   = line_rise[1] && scl_f;

    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic              ack_phase_reg, ack_phase_next;
    logic [6:0]        shift_reg, shift_next;
    logic              ack_en_reg, ack_en_next;
    logic [REG_AW-1:0] ptr_reg, ptr_next;
    logic [7:0]        tx_reg, tx_next;
    logic              oe_reg, oe_next;
    logic              pend_reg, pend_next;
    logic [HCW-1:0]    hold_reg, hold_next;
    logic              busy_reg, busy_next;
    logic              wr_stb_reg, wr_stb_next;
    logic [REG_AW-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]        wr_data_reg, wr_data_next;
    logic [7:0]        host_rdata_reg;
    logic              wr_en;
    logic [7:0]        wdata_c;
    logic [7:0]        mem_reg [0:DEPTH-1];

    // The byte completing on this rise: seven shifted bits plus current SDA.
    assign wdata_c = {shift_reg, sda_f};
    assign active  = (state_reg != ST_IDLE) && (state_reg != ST_IGNORE);

    // Next-state and datapath decode. Bus conditions override everything;
    // otherwise the hold timer applies the SDA level scheduled at the last
    // SCL fall, and SCL rises shift bits and close bytes.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        ack_phase_next = ack_phase_reg;
        shift_next     = shift_reg;
        ack_en_next    = ack_en_reg;
        ptr_next       = ptr_reg;
        tx_next        = tx_reg;
        oe_next        = oe_reg;
        pend_next      = pend_reg;
        hold_next      = hold_reg;
        busy_next      = busy_reg;
        wr_stb_next    = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        wr_en          = 1'b0;

        if (start_c) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = '0;
            ack_phase_next = 1'b0;
            oe_next        = 1'b0;
            hold_next      = '0;
        end else if (stop_c) begin
            state_next     = ST_IDLE;
            bit_cnt_next   = '0;
            ack_phase_next = 1'b0;
            oe_next        = 1'b0;
            hold_next      = '0;
            busy_next      = 1'b0;
        end else begin
            if (hold_reg != '0) begin
                hold_next = hold_reg - 1'b1;
                // Never move SDA while SCL is high; a late schedule is dropped.
                if (hold_reg == HCW'(1) && !scl_f) begin
                    oe_next = pend_reg;
                end
            end

            if (scl_fall && active) begin
                hold_next = HCW'(HOLD_CYC);
                if (ack_phase_reg) begin
                    pend_next = ack_en_reg;
                end else if (state_reg == ST_RDATA) begin
                    pend_next = ~tx_reg[3'd7 - bit_cnt_reg];
                end else begin
                    pend_next = 1'b0;
                end
            end

            if (scl_rise && active) begin
                if (!ack_phase_reg) begin
                    shift_next   = wdata_c[6:0];
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
                        ack_phase_next = 1'b1;
                        ack_en_next    = 1'b0;
                        case (state_reg)
                            ST_ADDR: begin
                                if (wdata_c[7:1] == DEV_ADDR) begin
                                    ack_en_next = 1'b1;
                                    busy_next   = 1'b1;
                                end else begin
                                    state_next = ST_IGNORE;
                                    busy_next  = 1'b0;
                                end
                            end
                            ST_PTR: begin
                                ptr_next    = REG_AW'(wdata_c);
                                ack_en_next = 1'b1;
                            end
                            ST_WDATA: begin
                                wr_en        = 1'b1;
                                wr_stb_next  = 1'b1;
                                wr_addr_next = ptr_reg;
                                wr_data_next = wdata_c;
                                ptr_next     = ptr_reg + 1'b1;
                                ack_en_next  = 1'b1;
                            end
                            ST_RDATA: begin
                                ptr_next = ptr_reg + 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end else begin
                    // Ninth (ACK) bit: shift_reg[0] still holds the R/W bit.
                    ack_phase_next = 1'b0;
                    bit_cnt_next   = '0;
                    case (state_reg)
                        ST_ADDR: begin
                            if (shift_reg[0]) begin
                                state_next = ST_RDATA;
                                tx_next    = mem_reg[ptr_reg];
                            end else begin
                                state_next = ST_PTR;
                            end
                        end
                        ST_PTR: state_next = ST_WDATA;
                        ST_RDATA: begin
                            if (sda_f) begin
                                state_next = ST_IGNORE;
                                busy_next  = 1'b0;
                            end else begin
                                tx_next = mem_reg[ptr_reg];
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Control and output state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            ack_phase_reg <= 1'b0;
            shift_reg     <= '0;
            ack_en_reg    <= 1'b0;
            ptr_reg       <= '0;
            tx_reg        <= '0;
            oe_reg        <= 1'b0;
            pend_reg      <= 1'b0;
            hold_reg      <= '0;
            busy_reg      <= 1'b0;
            wr_stb_reg    <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            ack_phase_reg <= ack_phase_next;
            shift_reg     <= shift_next;
            ack_en_reg    <= ack_en_next;
            ptr_reg       <= ptr_next;
            tx_reg        <= tx_next;
            oe_reg        <= oe_next;
            pend_reg      <= pend_next;
            hold_reg      <= hold_next;
            busy_reg      <= busy_next;
            wr_stb_reg    <= wr_stb_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    // Register file; cleared by reset so it cannot map onto block RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[ptr_reg] <= wdata_c;
        end
    end

    // Host read port with bypass so a same-cycle write shows next cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            host_rdata_reg <= '0;
        end else if (wr_en && (ptr_reg == host_raddr)) begin
            host_rdata_reg <= wdata_c;
        end else begin
            host_rdata_reg <= mem_reg[host_raddr];
        end
    end

    assign sda_oe     = oe_reg;
    assign busy       = busy_reg;
    assign wr_stb     = wr_stb_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_renesas_i2c_target.sv
// Bench for renesas_i2c_target: bit-banged I2C master over an open-drain
// SDA model, a transaction table for the main flows, hand sequences for
// glitches, aborts and reset, and a monitor for SDA hold and write strobes.
module tb_renesas_i2c_target;

    localparam int Q          = 12;
    localparam int HOLD_CYC   = 4;
    localparam int FILTER_LEN = 3;
    localparam int MIN_LOW    = HOLD_CYC + 2 + FILTER_LEN;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe, busy, wr_stb;
    logic [7:0] wr_addr, wr_data, host_rdata;
    logic [7:0] host_raddr = 8'h00;

    int checks = 0;
    int failures = 0;
    bit cond_window = 1'b0;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 aclk = ~aclk;

    renesas_i2c_target #(
        .DEV_ADDR  (7'h5B),
        .REG_AW    (8),
        .FILTER_LEN(FILTER_LEN),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .host_raddr(host_raddr),
        .host_rdata(host_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Hold monitor and write-strobe logger, sampled 2 ns after each edge.
    int         low_cnt = 0;
    logic       prev_oe = 1'b0;
    logic [7:0] log_a[$];
    logic [7:0] log_d[$];
    always @(posedge aclk) begin
        #2;
        if (scl_i) low_cnt = 0;
        else       low_cnt++;
        if (sda_oe !== prev_oe && !cond_window && aresetn) begin
            checks++;
            if (!(scl_i == 1'b0 && low_cnt >= MIN_LOW)) begin
                failures++;
                $display("FAIL hold oe=%0b scl=%0b low_cycles=%0d required>=%0d", sda_oe, scl_i, low_cnt, MIN_LOW);
            end
        end
        prev_oe = sda_oe;
        if (wr_stb === 1'b1) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge aclk);
    endtask

    task automatic send_bit(input bit b, input bit glitch, output bit line);
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        repeat (Q / 2) @(negedge aclk);
        line = sda_i;
        if (glitch) begin
            sda_m = ~b;
            repeat (2) @(negedge aclk);
            sda_m = b;
            repeat (Q / 2 - 2) @(negedge aclk);
        end else begin
            repeat (Q / 2) @(negedge aclk);
        end
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output bit ack);
        bit l;
        for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i], l);
        send_bit(1'b1, 1'b0, l);
        ack = ~l;
    endtask

    task automatic read_byte(input bit master_ack, output logic [7:0] d);
        bit l;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, l);
            d[i] = l;
        end
        send_bit(~master_ack, 1'b0, l);
    endtask

    task automatic bus_start();
        cond_window = 1'b1;
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
        cond_window = 1'b0;
    endtask

    task automatic bus_stop();
        cond_window = 1'b1;
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
        cond_window = 1'b0;
    endtask

    task automatic host_check(input string name, input logic [7:0] a, input logic [7:0] e);
        host_raddr = a;
        repeat (2) @(negedge aclk);
        check(name, host_rdata, e);
    endtask

    typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD, OP_HOST, OP_OE} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] d;   // byte sent / host address
        logic [7:0] e;   // expected read byte / host data / oe
        logic       a;   // expected target ACK (WR) or ACK sent by master (RD)
        logic       b;   // expected busy afterwards
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input op_t op, input logic [7:0] d, input logic [7:0] e,
                                input logic a, input logic b);
        vec_t v;
        v.op = op; v.d = d; v.e = e; v.a = a; v.b = b;
        tbl.push_back(v);
    endfunction

    initial begin
        bit         ack;
        bit         l;
        logic [7:0] rd;
        logic [7:0] exp_a[$];
        logic [7:0] exp_d[$];

        // Write 0xAA,0x55 at 0x10
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB6, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'h10, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'hAA, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'h55, 8'h00, 1'b1, 1'b1);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_HOST,  8'h11, 8'h55, 1'b0, 1'b0);
        add(OP_HOST,  8'h10, 8'hAA, 1'b0, 1'b0);
        add(OP_HOST,  8'h12, 8'h00, 1'b0, 1'b0);
        // Random read via repeated START
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB6, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'h10, 8'h00, 1'b1, 1'b1);
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b1);
        add(OP_WR,    8'hB7, 8'h00, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'hAA, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'h55, 1'b0, 1'b0);
        add(OP_OE,    8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        // Address mismatch, write and near-miss
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hA0, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB4, 8'h00, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        // Pointer wrap on write
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB6, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'hFF, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'h01, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'h02, 8'h00, 1'b1, 1'b1);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_HOST,  8'hFF, 8'h01, 1'b0, 1'b0);
        add(OP_HOST,  8'h00, 8'h02, 1'b0, 1'b0);
        // Pointer wrap on read
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB6, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'hFF, 8'h00, 1'b1, 1'b1);
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b1);
        add(OP_WR,    8'hB7, 8'h00, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'h01, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'h02, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        // Pointer persists across STOP
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB6, 8'h00, 1'b1, 1'b1);
        add(OP_WR,    8'h10, 8'h00, 1'b1, 1'b1);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_START, 8'h00, 8'h00, 1'b0, 1'b0);
        add(OP_WR,    8'hB7, 8'h00, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'hAA, 1'b1, 1'b1);
        add(OP_RD,    8'h00, 8'h55, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_START: begin
                    bus_start();
                    check($sformatf("t%0d_start_busy", i), busy, tbl[i].b);
                end
                OP_STOP: begin
                    bus_stop();
                    check($sformatf("t%0d_stop_busy", i), busy, tbl[i].b);
                    check($sformatf("t%0d_stop_oe", i), sda_oe, 0);
                end
                OP_WR: begin
                    write_byte(tbl[i].d, 8'h00, ack);
                    check($sformatf("t%0d_wr_ack", i), ack, tbl[i].a);
                    check($sformatf("t%0d_wr_busy", i), busy, tbl[i].b);
                end
                OP_RD: begin
                    read_byte(tbl[i].a, rd);
                    check($sformatf("t%0d_rd_data", i), rd, tbl[i].e);
                    check($sformatf("t%0d_rd_busy", i), busy, tbl[i].b);
                end
                OP_HOST: host_check($sformatf("t%0d_host", i), tbl[i].d, tbl[i].e);
                default: check($sformatf("t%0d_oe", i), sda_oe, tbl[i].e);
            endcase
            $display("txn %0d %s d=%02h e=%02h a=%0b b=%0b", i, tbl[i].op.name(),
                     tbl[i].d, tbl[i].e, tbl[i].a, tbl[i].b);
        end
        check("hold_wr_addr", wr_addr, 8'h00);
        check("hold_wr_data", wr_data, 8'h02);

        // Short SDA glitch on an idle bus must not look like START
        @(negedge aclk); sda_m = 1'b0;
        @(negedge aclk); @(negedge aclk); sda_m = 1'b1;
        wait_q();
        scl_m = 1'b0;
        wait_q();
        write_byte(8'hB6, 8'h00, ack);
        check("glitch_idle_ack", ack, 0);
        check("glitch_idle_busy", busy, 0);
        bus_stop();
        $display("txn glitch_idle");

        // STOP-like and START-like glitches inside a data byte
        bus_start();
        write_byte(8'hB6, 8'h00, ack);
        write_byte(8'h20, 8'h00, ack);
        write_byte(8'h0F, 8'h22, ack);
        check("glitch_data_ack", ack, 1);
        check("glitch_data_busy", busy, 1);
        bus_stop();
        host_check("glitch_data_host", 8'h20, 8'h0F);
        $display("txn glitch_data");

        // START after 4 data bits discards the partial byte
        bus_start();
        write_byte(8'hB6, 8'h00, ack);
        write_byte(8'h30, 8'h00, ack);
        send_bit(1'b1, 1'b0, l);
        send_bit(1'b0, 1'b0, l);
        send_bit(1'b1, 1'b0, l);
        send_bit(1'b0, 1'b0, l);
        bus_start();
        write_byte(8'hB6, 8'h00, ack);
        check("abort_restart_ack", ack, 1);
        write_byte(8'h31, 8'h00, ack);
        write_byte(8'h77, 8'h00, ack);
        bus_stop();
        host_check("abort_host30", 8'h30, 8'h00);
        host_check("abort_host31", 8'h31, 8'h77);
        $display("txn abort_partial");

        // Reset in the middle of a read
        bus_start();
        write_byte(8'hB6, 8'h00, ack);
        write_byte(8'h10, 8'h00, ack);
        bus_start();
        write_byte(8'hB7, 8'h00, ack);
        send_bit(1'b1, 1'b0, l);
        check("midread_bit7", l, 1);
        check("midread_oe_low_bit", sda_oe, 1);
        aresetn = 1'b0;
        #1;
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_stb", wr_stb, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_host_rdata", host_rdata, 0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, l);
        check("postrst_ignored_line", l, 1);
        check("postrst_oe", sda_oe, 0);
        bus_stop();
        host_check("postrst_host10", 8'h10, 8'h00);
        bus_start();
        write_byte(8'hB6, 8'h00, ack);
        check("postrst_addr_ack", ack, 1);
        check("postrst_busy", busy, 1);
        write_byte(8'h05, 8'h00, ack);
        write_byte(8'h99, 8'h00, ack);
        bus_stop();
        host_check("postrst_host05", 8'h05, 8'h99);
        $display("txn reset_mid_read");

        // Every write strobe, in order
        exp_a = '{8'h10, 8'h11, 8'hFF, 8'h00, 8'h20, 8'h31, 8'h05};
        exp_d = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h0F, 8'h77, 8'h99};
        check("wr_stb_count", log_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            check($sformatf("wr_log%0d_addr", i), log_a[i], exp_a[i]);
            check($sformatf("wr_log%0d_data", i), log_d[i], exp_d[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
